// File: rtl/shift_seq_unit_pkg.sv
// Shared encodings for the multi-cycle shift unit and the ALU decoder.
package shift_seq_unit_pkg;

    // Shift type as decoded from the instruction.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_RSV = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_seq_unit_step1.sv
// One-bit shift of a WIDTH-bit word, selected by shift type.
// Reserved op passes the word through unchanged.
module shift_seq_unit_step1
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] dout
);

    // Select the single-position shift for the requested type.
    always_comb begin
        // NOTE: every combinational output gets a value on every path (default
        // branch here) so no latch is inferred.
        case (shift_op_e'(op))
            OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift execution unit: one bit per clock with a start/busy/done
// handshake. Holds the sequencer FSM, the remaining-shift counter and the
// result register.
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shift,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    shift_state_e     state_q, state_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] step_res;
    logic             accept;

    shift_seq_unit_step1 #(
        .WIDTH (WIDTH)
    ) u_step1 (
        .din  (res_q),
        .op   (op_q),
        .dout (step_res)
    );

    // A request is taken whenever the unit is not mid-shift (IDLE or DONE).
    assign accept = start && (state_q != S_SHIFT);

    // Next-state, counter and result-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;

        if (accept) begin
            res_d = A;
            op_d  = op;
            cnt_d = shift;
            // Zero-length or reserved shifts complete without entering SHIFT.
            if (shift == '0 || op == OP_RSV) begin
                state_d = S_DONE;
            end else begin
                state_d = S_SHIFT;
            end
        end else begin
            case (state_q)
                S_SHIFT: begin
                    res_d = step_res;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign res  = res_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: a vector table plus hand-written
// sequences for back-to-back starts, ignored starts and mid-shift reset.
module tb_shift_seq_unit;
    import shift_seq_unit_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shift;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    shift_seq_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (a),
        .shift (shift),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the inputs so only the
    // latched copies can produce the right answer.
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [4:0] sh);
        start = 1'b1;
        op    = o;
        a     = av;
        shift = sh;
        step();
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        shift = 5'($urandom);
    endtask

    // Called right after the accept edge; lat counts samples up to done.
    task automatic wait_done(input int limit, output int lat, output int busy_n, output bit seen);
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            lat = i;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        int lat;
        int busy_n;
        bit seen;
        int done_cnt;

        vecs[0]  = '{OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 5,  4};
        vecs[1]  = '{OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 5,  4};
        vecs[2]  = '{OP_SRA, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 5,  4};
        vecs[3]  = '{OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 31};
        vecs[4]  = '{OP_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1,  0};
        vecs[5]  = '{OP_RSV, 32'h1234_5678, 5'd7,  32'h1234_5678, 1,  0};
        vecs[6]  = '{OP_SLL, 32'h1234_5678, 5'd4,  32'h2345_6780, 5,  4};
        vecs[7]  = '{OP_SRA, 32'h1234_5678, 5'd8,  32'h0012_3456, 9,  8};
        vecs[8]  = '{OP_SRA, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 32, 31};
        vecs[9]  = '{OP_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 32, 31};
        vecs[10] = '{OP_SLL, 32'h0000_F00F, 5'd12, 32'h0F00_F000, 13, 12};
        vecs[11] = '{OP_SRA, 32'h8000_0001, 5'd1,  32'hC000_0000, 2,  1};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        shift = '0;
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset res",  res,       32'h0);
        rst = 1'b0;
        step();
        check("idle busy", 32'(busy), 32'd0);

        // Table-driven vectors.
        for (int v = 0; v < 12; v++) begin
            issue(vecs[v].op, vecs[v].a, vecs[v].sh);
            wait_done(40, lat, busy_n, seen);
            check($sformatf("v%0d done seen", v), 32'(seen), 32'd1);
            check($sformatf("v%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d busy cycles", v), 32'(busy_n), 32'(vecs[v].exp_busy));
            check($sformatf("v%0d res", v), res, vecs[v].exp_res);
            step();
            check($sformatf("v%0d done pulse width", v), 32'(done), 32'd0);
            check($sformatf("v%0d res hold", v), res, vecs[v].exp_res);
        end

        // Back-to-back: new start in the DONE cycle.
        issue(OP_SLL, 32'h0000_0001, 5'd31);
        wait_done(40, lat, busy_n, seen);
        check("b2b first latency", 32'(lat), 32'd32);
        check("b2b first res", res, 32'h8000_0000);
        start = 1'b1;
        op    = OP_SRL;
        a     = 32'hFFFF_FFFF;
        shift = 5'd1;
        step();
        start = 1'b0;
        check("b2b accepted busy", 32'(busy), 32'd1);
        wait_done(5, lat, busy_n, seen);
        check("b2b second latency", 32'(lat), 32'd2);
        check("b2b second res", res, 32'h7FFF_FFFF);
        step();

        // Start pulsed during SHIFT must be ignored.
        issue(OP_SRL, 32'hFFFF_FFFF, 5'd16);
        step();
        step();
        start = 1'b1;
        op    = OP_SRL;
        a     = 32'h0;
        shift = 5'd1;
        step();
        start = 1'b0;
        check("ignore busy", 32'(busy), 32'd1);
        wait_done(40, lat, busy_n, seen);
        check("ignore latency", 32'(lat + 3), 32'd17);
        check("ignore res", res, 32'h0000_FFFF);
        step();

        // Reset in the middle of a shift aborts it.
        issue(OP_SRL, 32'hFFFF_FFFF, 5'd16);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort res",  res,       32'h0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("abort no done", 32'(done_cnt), 32'd0);
        check("abort res stays", res, 32'h0);
        issue(OP_SRL, 32'h0000_00F0, 5'd4);
        wait_done(40, lat, busy_n, seen);
        check("post-reset latency", 32'(lat), 32'd5);
        check("post-reset res", res, 32'h0000_000F);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
